// File: rtl/pulse_gen_pkg.sv
// ---------------------------------------------------------------------------
// pulse_gen_pkg
// Shared definitions for the pulse generator and its prescaler:
//   TIMING_DEFAULT : default prescaler terminal value (tick every TIMING+1 clks)
//   PERIOD_W       : width of period, shadow and tick counters
//   MIN_PERIOD     : smallest period that yields one high and one low tick
//   state_t        : generator FSM states
//   clamp_period() : raises requested periods below MIN_PERIOD to MIN_PERIOD
// ---------------------------------------------------------------------------
package pulse_gen_pkg;

  localparam logic [4:0] TIMING_DEFAULT = 5'd10;
  localparam int         PERIOD_W       = 16;
  localparam logic [PERIOD_W-1:0] MIN_PERIOD = 16'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p);
    return (p < MIN_PERIOD) ? MIN_PERIOD : p;
  endfunction

endpackage

// File: rtl/pulse_gen_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Free-running prescaler: counts 0..TIMING and wraps, asserting tick while the
// count sits at TIMING, i.e. one tick every TIMING+1 clocks.
// Ports:
//   CLK  in  : clock
//   rst  in  : synchronous active-high reset (count returns to 0)
//   tick out : high for one clock every TIMING+1 clocks
// ---------------------------------------------------------------------------
module tick_gen
  import pulse_gen_pkg::*;
#(
  parameter logic [4:0] TIMING = TIMING_DEFAULT
) (
  input  logic CLK,
  input  logic rst,
  output logic tick
);

  logic [4:0] r_count;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_count <= '0;
    end else if (r_count == TIMING) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 5'd1;
    end
  end

  assign tick = (r_count == TIMING);

endmodule

// File: rtl/pulse_gen.sv
// ---------------------------------------------------------------------------
// pulse_gen
// Tick-based pulse train generator. Each period starts with a rising edge and
// a one-clock cycle_done strobe; the pulse is high for floor(P/2) ticks and low
// for the remaining ticks. New periods are latched from a shadow register at
// the start of each period, so loads never disturb a period in progress.
// Dropping enable lets the current period finish before going idle.
// Ports:
//   CLK           in   : clock
//   rst           in   : synchronous active-high reset
//   enable        in   : run the pulse train
//   period_in     in   : requested period in ticks
//   period_load   in   : strobe, captures max(period_in, 2) into the shadow
//   pulse         out  : registered pulse train
//   cycle_done    out  : one-clock strobe coincident with each rising edge
//   period_active out  : period currently being generated
// ---------------------------------------------------------------------------
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter logic [4:0]          TIMING     = TIMING_DEFAULT,
  parameter logic [PERIOD_W-1:0] PERIOD_RST = 16'd100
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period_in,
  input  logic                period_load,
  output logic                pulse,
  output logic                cycle_done,
  output logic [PERIOD_W-1:0] period_active
);

  logic                w_tick;
  logic [PERIOD_W-1:0] w_high_len;

  state_t              r_state,      w_state_nxt;
  logic [PERIOD_W-1:0] r_period,     w_period_nxt;
  logic [PERIOD_W-1:0] r_tick_cnt,   w_tick_cnt_nxt;
  logic                r_pulse,      w_pulse_nxt;
  logic                r_cycle_done, w_cycle_done_nxt;
  logic [PERIOD_W-1:0] r_shadow;

  tick_gen #(.TIMING(TIMING)) u_tick_gen (
    .CLK  (CLK),
    .rst  (rst),
    .tick (w_tick)
  );

  assign w_high_len = r_period >> 1;

  // A load on the same clock as a period start lands in the shadow while
  // r_period takes the old shadow value, so it only affects the next period.
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_shadow <= PERIOD_RST;
    end else if (period_load) begin
      r_shadow <= clamp_period(period_in);
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state      <= IDLE;
      r_period     <= PERIOD_RST;
      r_tick_cnt   <= '0;
      r_pulse      <= 1'b0;
      r_cycle_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_period     <= w_period_nxt;
      r_tick_cnt   <= w_tick_cnt_nxt;
      r_pulse      <= w_pulse_nxt;
      r_cycle_done <= w_cycle_done_nxt;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt      = r_state;
    w_period_nxt     = r_period;
    w_tick_cnt_nxt   = r_tick_cnt;
    w_pulse_nxt      = r_pulse;
    w_cycle_done_nxt = 1'b0;

    if (w_tick) begin
      unique case (r_state)
        IDLE: begin
          if (enable) begin
            w_state_nxt      = HIGH;
            w_period_nxt     = r_shadow;
            w_tick_cnt_nxt   = 16'd1;
            w_pulse_nxt      = 1'b1;
            w_cycle_done_nxt = 1'b1;
          end
        end
        HIGH: begin
          // tick_cnt keeps running into LOW so it reaches period_active
          // exactly at the end of the period.
          w_tick_cnt_nxt = r_tick_cnt + 16'd1;
          if (r_tick_cnt == w_high_len) begin
            w_state_nxt = LOW;
            w_pulse_nxt = 1'b0;
          end
        end
        LOW: begin
          if (r_tick_cnt == r_period) begin
            if (enable) begin
              w_state_nxt      = HIGH;
              w_period_nxt     = r_shadow;
              w_tick_cnt_nxt   = 16'd1;
              w_pulse_nxt      = 1'b1;
              w_cycle_done_nxt = 1'b1;
            end else begin
              w_state_nxt    = IDLE;
              w_tick_cnt_nxt = '0;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 16'd1;
          end
        end
        default: begin
          w_state_nxt    = IDLE;
          w_tick_cnt_nxt = '0;
          w_pulse_nxt    = 1'b0;
        end
      endcase
    end
  end

  assign pulse         = r_pulse;
  assign cycle_done    = r_cycle_done;
  assign period_active = r_period;

endmodule

// File: tb/tb_pulse_gen.sv
// ---------------------------------------------------------------------------
// tb_pulse_gen
// Directed bench for pulse_gen with TIMING=10 (11 clocks per tick) and
// PERIOD_RST=100. Pulse widths are counted in clocks, sampled on falling edges.
// ---------------------------------------------------------------------------
module tb_pulse_gen;

  localparam int LIM = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] period_in;
  logic        period_load;
  logic        pulse;
  logic        cycle_done;
  logic [15:0] period_active;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pulse_gen #(.TIMING(5'd10), .PERIOD_RST(16'd100)) dut (
    .CLK           (clk),
    .rst           (rst),
    .enable        (enable),
    .period_in     (period_in),
    .period_load   (period_load),
    .pulse         (pulse),
    .cycle_done    (cycle_done),
    .period_active (period_active)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Waits (bounded) for cycle_done; n is the number of falling edges waited.
  task automatic wait_cd(input int max, output int n);
    n = 0;
    while (cycle_done !== 1'b1 && n < max) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Called on the falling edge right after a rising edge of pulse. Counts the
  // clocks of the high and low phases; optionally strobes period_load at a
  // given clock index of the high or low phase, or drops enable in HIGH.
  task automatic measure(input int ld_hi, input int ld_lo, input logic [15:0] ld_val,
                         input int drop_at, input int lim,
                         output int hi, output int lo,
                         output logic cd2, output logic cd_low, output logic cd_end);
    hi = 0; lo = 0; cd2 = 1'b0; cd_low = 1'b0;
    period_in = ld_val;
    while (pulse === 1'b1 && hi < lim) begin
      period_load = (hi == ld_hi);
      if (hi == drop_at) enable = 1'b0;
      hi++;
      @(negedge clk);
      if (hi == 1) cd2 = cycle_done;
    end
    while (pulse === 1'b0 && lo < lim) begin
      period_load = (lo == ld_lo);
      lo++;
      @(negedge clk);
      if (pulse === 1'b0 && cycle_done === 1'b1) cd_low = 1'b1;
    end
    period_load = 1'b0;
    cd_end = cycle_done;
  endtask

  task automatic run_period(input string tag, input int ld_hi, input int ld_lo,
                            input logic [15:0] ld_val, input int exp_hi, input int exp_lo,
                            output int tot);
    int   hi, lo;
    logic cd2, cd_low, cd_end;
    measure(ld_hi, ld_lo, ld_val, -1, LIM, hi, lo, cd2, cd_low, cd_end);
    check({tag, "_high_clks"}, hi, exp_hi);
    check({tag, "_low_clks"}, lo, exp_lo);
    check({tag, "_cd_one_clk"}, cd2, 1'b0);
    check({tag, "_cd_none_low"}, cd_low, 1'b0);
    check({tag, "_cd_at_rise"}, cd_end, 1'b1);
    tot = hi + lo;
  endtask

  initial begin
    int   n, tot, hi, lo;
    logic cd2, cd_low, cd_end;

    rst = 1'b1; enable = 1'b0; period_load = 1'b0; period_in = '0;
    repeat (3) @(negedge clk);
    check("rst_pulse", pulse, 1'b0);
    check("rst_cycle_done", cycle_done, 1'b0);
    check("rst_period_active", period_active, 100);
    rst = 1'b0;

    // Load 4 while idle: shadow only, period_active unchanged.
    period_in = 16'd4; period_load = 1'b1;
    @(negedge clk);
    period_load = 1'b0;
    @(negedge clk);
    check("idle_period_active", period_active, 100);
    check("idle_pulse", pulse, 1'b0);

    enable = 1'b1;
    wait_cd(40, n);
    check("start_latency_in_range", (n >= 1 && n <= 11), 1'b1);
    check("p4_period_active", period_active, 4);
    run_period("p4", -1, -1, 16'd0, 22, 22, tot);
    check("p4_spacing", tot, 44);

    // Load 5 mid-HIGH of a period of 4.
    run_period("p4_ld5", 3, -1, 16'd5, 22, 22, tot);
    check("p5_period_active", period_active, 5);
    run_period("p5", -1, -1, 16'd0, 22, 33, tot);
    check("p5_loopback", tot / 11 - 1, 4);

    // Load 4 on the very clock the next period starts: that period stays 5.
    run_period("p5_ld4_at_start", -1, 32, 16'd4, 22, 33, tot);
    check("p5_kept_after_edge_load", period_active, 5);
    run_period("p5_last", -1, -1, 16'd0, 22, 33, tot);
    check("p4_again_period_active", period_active, 4);

    // Running at 4, load 8 mid-HIGH.
    run_period("p4_ld8_mid", 5, -1, 16'd8, 22, 22, tot);
    check("p8_period_active", period_active, 8);

    // Clamping: load 0 then load 1, both give 2.
    run_period("p8_ld0", 2, -1, 16'd0, 44, 44, tot);
    check("clamp0_period_active", period_active, 2);
    run_period("p2_ld1", 0, -1, 16'd1, 11, 11, tot);
    check("clamp1_period_active", period_active, 2);

    // Period 6, enable dropped one tick into HIGH: full period, then idle.
    run_period("p2_ld6", 0, -1, 16'd6, 11, 11, tot);
    check("p6_period_active", period_active, 6);
    measure(-1, -1, 16'd0, 11, 200, hi, lo, cd2, cd_low, cd_end);
    check("drop_high_clks", hi, 33);
    check("drop_stays_low", lo, 200);
    check("drop_no_cycle_done", cd_low, 1'b0);
    check("drop_pulse_idle", pulse, 1'b0);

    enable = 1'b1;
    wait_cd(40, n);
    check("restart_latency_in_range", (n >= 1 && n <= 11), 1'b1);
    run_period("p6_restart", -1, -1, 16'd0, 33, 33, tot);

    // Reset mid-HIGH, with load and enable also active on the reset clock.
    repeat (5) @(negedge clk);
    rst = 1'b1; period_load = 1'b1; period_in = 16'd7;
    @(negedge clk);
    rst = 1'b0; period_load = 1'b0;
    check("midrst_pulse", pulse, 1'b0);
    check("midrst_period_active", period_active, 100);
    check("midrst_cycle_done", cycle_done, 1'b0);
    wait_cd(40, n);
    check("midrst_first_tick_latency", n, 11);
    check("p100_period_active", period_active, 100);
    run_period("p100", -1, -1, 16'd0, 550, 550, tot);
    check("p100_shadow_kept", period_active, 100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
